wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 31 +++
 rtl/wb_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-source request channels plus the single
// registered writeback port toward the register file / scoreboard.
// The "slave" modport is the arbiter side; "master" is the side that
// issues requests and observes writebacks.
interface wb_arbiter_if #(
   parameter int DATA_W = 64
);
   logic [2:0]          req_valid;
   logic [2:0]          req_ready;
   logic [11:0]         req_rD;
   logic [11:0]         req_mask;
   logic [3*DATA_W-1:0] req_data;

   logic                wb_rf_we;
   logic [3:0]          wb_rD_addr;
   logic [3:0]          wb_active_mask;
   logic [DATA_W-1:0]   wb_data;
   logic [1:0]          wb_src;

   modport master (
      output req_valid, req_rD, req_mask, req_data,
      input  req_ready,
      input  wb_rf_we, wb_rD_addr, wb_active_mask, wb_data, wb_src
   );

   modport slave (
      input  req_valid, req_rD, req_mask, req_data,
      output req_ready,
      output wb_rf_we, wb_rD_addr, wb_active_mask, wb_data, wb_src
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three sources (0 MEM, 1 SFU, 2 ALU) each feed a
// 2-entry FIFO of {rD, mask, data}. One non-empty head is granted per
// cycle, dequeued and loaded into the registered wb_* outputs at the same
// edge. Heads with an all-zero thread mask are drained without a write.
// Optional feature macro: WB_ARB_RR_EN selects round-robin arbitration;
// when undefined, fixed priority MEM > SFU > ALU is used.
module wb_arbiter #(
   parameter int DATA_W = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   wb_arbiter_if.slave   bus,
   output logic          idle,
   output logic [15:0]   conflict_cnt
);
   localparam int ENT_W = 8 + DATA_W;

   logic [2:0]       nonempty;
   logic [2:0]       ready;
   logic [2:0]       enq;
   logic [2:0]       deq;
   logic [ENT_W-1:0] head [3];

   logic             grant_valid;
   logic [1:0]       grant_idx;
   logic [ENT_W-1:0] head_sel;
   logic             two_plus;

   logic             wb_rf_we_reg;
   logic [3:0]       wb_rD_addr_reg;
   logic [3:0]       wb_active_mask_reg;
   logic [DATA_W-1:0] wb_data_reg;
   logic [1:0]       wb_src_reg;
   logic [15:0]      conflict_cnt_reg;

   // Per-source FIFO: ready depends only on the registered count, and a
   // slot freed by this edge's dequeue is not offered until the next cycle.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
         logic [1:0]       count_reg;
         logic             wr_ptr_reg;
         logic             rd_ptr_reg;
         logic [ENT_W-1:0] mem_reg [2];
         logic [ENT_W-1:0] wr_entry;

         assign wr_entry    = {bus.req_rD[4*gi +: 4], bus.req_mask[4*gi +: 4],
                               bus.req_data[DATA_W*gi +: DATA_W]};
         assign nonempty[gi] = (count_reg != 2'd0);
         assign ready[gi]    = (count_reg != 2'd2);
         assign enq[gi]      = bus.req_valid[gi] & ready[gi];
         assign deq[gi]      = grant_valid && (grant_idx == 2'(gi));
         assign head[gi]     = mem_reg[rd_ptr_reg];

         // Occupancy and pointers; simultaneous push and pop keep the count.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               count_reg  <= 2'd0;
               wr_ptr_reg <= 1'b0;
               rd_ptr_reg <= 1'b0;
            end else begin
               if (enq[gi]) wr_ptr_reg <= ~wr_ptr_reg;
               if (deq[gi]) rd_ptr_reg <= ~rd_ptr_reg;
               case ({enq[gi], deq[gi]})
                  2'b10:   count_reg <= count_reg + 2'd1;
                  2'b01:   count_reg <= count_reg - 2'd1;
                  default: count_reg <= count_reg;
               endcase
            end
         end

         // Entry storage; contents are only meaningful while counted valid.
         always_ff @(posedge clk) begin
            if (enq[gi]) mem_reg[wr_ptr_reg] <= wr_entry;
         end
      end
   endgenerate

   assign bus.req_ready = ready;

`ifdef WB_ARB_RR_EN
   logic [1:0] rr_ptr_reg;

   // Round-robin pick: first non-empty source starting at the pointer.
   always_comb begin
      logic [2:0] sum;
      logic [1:0] cand;
      grant_valid = 1'b0;
      grant_idx   = 2'd0;
      sum         = 3'd0;
      cand        = 2'd0;
      for (int k = 0; k < 3; k++) begin
         sum  = {1'b0, rr_ptr_reg} + 3'(k);
         cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
         if (!grant_valid && nonempty[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Pointer moves just past the source that was granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg <= 2'd0;
      end else if (grant_valid) begin
         rr_ptr_reg <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end
   end
`else
   // Fixed priority pick: MEM first, then SFU, then ALU.
   always_comb begin
      grant_valid = 1'b1;
      grant_idx   = 2'd0;
      if (nonempty[0])      grant_idx = 2'd0;
      else if (nonempty[1]) grant_idx = 2'd1;
      else if (nonempty[2]) grant_idx = 2'd2;
      else                  grant_valid = 1'b0;
   end
`endif

   // Select the head entry of the granted source.
   always_comb begin
      head_sel = head[0];
      case (grant_idx)
         2'd1:    head_sel = head[1];
         2'd2:    head_sel = head[2];
         default: head_sel = head[0];
      endcase
   end

   assign two_plus = (nonempty[0] & nonempty[1]) | (nonempty[0] & nonempty[2]) |
                     (nonempty[1] & nonempty[2]);

   // Writeback register: one-cycle strobe per grant, fields hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_rf_we_reg       <= 1'b0;
         wb_rD_addr_reg     <= 4'd0;
         wb_active_mask_reg <= 4'd0;
         wb_data_reg        <= '0;
         wb_src_reg         <= 2'd0;
      end else if (grant_valid) begin
         wb_rf_we_reg       <= |head_sel[ENT_W-5 -: 4];
         wb_rD_addr_reg     <= head_sel[ENT_W-1 -: 4];
         wb_active_mask_reg <= head_sel[ENT_W-5 -: 4];
         wb_data_reg        <= head_sel[DATA_W-1:0];
         wb_src_reg         <= grant_idx;
      end else begin
         wb_rf_we_reg       <= 1'b0;
      end
   end

   // Saturating count of edges where more than one source was waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt_reg <= 16'd0;
      end else if (two_plus && (conflict_cnt_reg != 16'hFFFF)) begin
         conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
      end
   end

   assign bus.wb_rf_we       = wb_rf_we_reg;
   assign bus.wb_rD_addr     = wb_rD_addr_reg;
   assign bus.wb_active_mask = wb_active_mask_reg;
   assign bus.wb_data        = wb_data_reg;
   assign bus.wb_src         = wb_src_reg;
   assign conflict_cnt       = conflict_cnt_reg;
   assign idle               = ~(|nonempty) & ~wb_rf_we_reg;
endmodule
